aether_engine_sequencer: RTL and testbench

AETHER_ENGINE_SEQUENCER -- requirements
Module: aether_engine_sequencer

---
 rtl/aether_engine_sequencer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_aether_engine_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aether_engine_sequencer.sv
// ---------------------------------------------------------------------------
// aether_engine_sequencer
//
// Purpose
//   Queues host commands in a small FIFO and issues them one at a time to the
//   Aether instruction decoder. Short commands issue back to back, one per
//   cycle. Long-running commands (CNV, DNS, weight-moving LDW) hold the
//   sequencer in WAIT until the datapath pulses op_done_i or a cycle budget
//   runs out. A full RST issue flushes everything still queued. An RDR issue
//   captures the decoder read data.
//
// Ports
//   clk_i, rst_i          clock; asynchronous active-high reset
//   cmd_valid_i/ready_o   host command handshake
//   cmd_instr_i/p1_i/p2_i command opcode and parameters
//   instruction_o,
//   param_1_o, param_2_o  registered command presented to the decoder
//   op_done_i             completion pulse for long-running commands
//   data_i                decoder read data, sampled when an RDR issues
//   rd_data_o/rd_valid_o  captured RDR result and its one-cycle strobe
//   busy_o                work in flight or queued
//   timeout_o             sticky flag: a WAIT was ended by the cycle budget
//   fifo_count_o          current FIFO occupancy
//
// Opcode encoding (shared Aether instruction set)
//   NOP=0 RST=1 WRR=2 RDR=3 LDW=4 CNV=5 DNS=6 LIP=7
//   LDW p1: STRT=0 CONT=1 CWGT=2 DWGT=3 MOVE=4
//   RST p1: FULL=0 ACC=1 BUF=2 (any other p1 is treated as FULL)
// ---------------------------------------------------------------------------
module aether_engine_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [3:0]                    cmd_instr_i,
  input  logic [3:0]                    cmd_p1_i,
  input  logic [15:0]                   cmd_p2_i,
  output logic [3:0]                    instruction_o,
  output logic [3:0]                    param_1_o,
  output logic [15:0]                   param_2_o,
  input  logic                          op_done_i,
  input  logic [15:0]                   data_i,
  output logic [15:0]                   rd_data_o,
  output logic                          rd_valid_o,
  output logic                          busy_o,
  output logic                          timeout_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  // The counter starts at 0 on WAIT entry, so the last permitted WAIT cycle
  // sees TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_RST = 4'h1;
  localparam logic [3:0] OP_RDR = 4'h3;
  localparam logic [3:0] OP_LDW = 4'h4;
  localparam logic [3:0] OP_CNV = 4'h5;
  localparam logic [3:0] OP_DNS = 4'h6;

  localparam logic [3:0] LDW_CWGT = 4'h2;
  localparam logic [3:0] LDW_DWGT = 4'h3;
  localparam logic [3:0] LDW_MOVE = 4'h4;

  localparam logic [3:0] RST_ACC = 4'h1;
  localparam logic [3:0] RST_BUF = 4'h2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t          state_q,    state_d;
  logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]   count_q,    count_d;
  logic [3:0]      instr_q,    instr_d;
  logic [3:0]      p1_q,       p1_d;
  logic [15:0]     p2_q,       p2_d;
  logic [15:0]     rd_data_q,  rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            timeout_q,  timeout_d;
  logic [TW-1:0]   wait_cnt_q, wait_cnt_d;

  logic [23:0]     fifo_mem_q [FIFO_DEPTH];

  logic [23:0]     head_word;
  logic            fifo_empty;
  logic            is_long;
  logic            flush;
  logic            push;
  logic            pop;

  // -------------------------------------------------------------------------
  // Command classification (on the command currently being issued)
  // -------------------------------------------------------------------------
  assign head_word  = fifo_mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);

  assign is_long = (instr_q == OP_CNV) ||
                   (instr_q == OP_DNS) ||
                   ((instr_q == OP_LDW) &&
                    ((p1_q == LDW_CWGT) || (p1_q == LDW_DWGT) || (p1_q == LDW_MOVE)));

  // Only ACC and BUF are partial resets; FULL and every undefined RST code
  // flush the queue.
  assign flush = (state_q == ST_ISSUE) && (instr_q == OP_RST) &&
                 (p1_q != RST_ACC) && (p1_q != RST_BUF);

  // Ready is gated by rst_i directly so it reads 0 while reset is held, and
  // by flush so nothing slips into a queue that is being discarded.
  assign cmd_ready_o = !rst_i && (count_q < DEPTH_C) && !flush;
  assign push        = cmd_valid_i && cmd_ready_o;

  // -------------------------------------------------------------------------
  // FSM next-state and output-register logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    instr_d    = OP_NOP;      // outputs fall back to NOP unless a pop loads them
    p1_d       = '0;
    p2_d       = '0;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    timeout_d  = timeout_q;
    wait_cnt_d = wait_cnt_q;
    pop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop                   = 1'b1;
          {instr_d, p1_d, p2_d} = head_word;
          state_d               = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (instr_q == OP_RDR) begin
          rd_data_d  = data_i;
          rd_valid_d = 1'b1;
        end

        if (flush) begin
          timeout_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (is_long) begin
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end else if (!fifo_empty) begin
          // Chain straight into the next command: one issue per cycle.
          pop                   = 1'b1;
          {instr_d, p1_d, p2_d} = head_word;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        // Completion wins over a coincident timeout.
        if (op_done_i) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FIFO pointer / occupancy logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly log2(depth) wide, so they wrap naturally.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      instr_q    <= OP_NOP;
      p1_q       <= '0;
      p2_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      timeout_q  <= timeout_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define which entries are
  // live, and push can never fire while rst_i is high.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {cmd_instr_i, cmd_p1_i, cmd_p2_i};
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign instruction_o = instr_q;
  assign param_1_o     = p1_q;
  assign param_2_o     = p2_q;
  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = rd_valid_q;
  assign timeout_o     = timeout_q;
  assign fifo_count_o  = count_q;
  assign busy_o        = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_aether_engine_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aether_engine_sequencer
//
// Two sequencers share one stimulus stream: dut_a with an 8-cycle WAIT
// budget and dut_b with the default budget. A queue-based reference model,
// one per instance, predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_aether_engine_sequencer;

  localparam int D     = 4;
  localparam int CW    = $clog2(D) + 1;
  localparam int TO_A  = 8;
  localparam int TO_B  = 65535;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_RST = 4'h1;
  localparam logic [3:0] OP_WRR = 4'h2;
  localparam logic [3:0] OP_RDR = 4'h3;
  localparam logic [3:0] OP_LDW = 4'h4;
  localparam logic [3:0] OP_CNV = 4'h5;
  localparam logic [3:0] OP_DNS = 4'h6;

  localparam logic [3:0] RST_FULL  = 4'h0;
  localparam logic [3:0] RST_ACC   = 4'h1;
  localparam logic [3:0] RST_BUF   = 4'h2;
  localparam logic [3:0] REG_MEMUP = 4'h1;
  localparam logic [3:0] REG_MSTRT = 4'h2;

  localparam int M_IDLE  = 0;
  localparam int M_ISSUE = 1;
  localparam int M_WAIT  = 2;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid;
  logic [3:0]  cmd_instr, cmd_p1;
  logic [15:0] cmd_p2;
  logic op_done;
  logic [15:0] data_in;

  logic [1:0]          ready_o, rdv_o, busy_o, tmo_o;
  logic [1:0][3:0]     ins_o, p1_o;
  logic [1:0][15:0]    p2_o, rdd_o;
  logic [1:0][CW-1:0]  cnt_o;

  always #5 clk = ~clk;

  aether_engine_sequencer #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(TO_A)) dut_a (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(ready_o[0]),
    .cmd_instr_i(cmd_instr), .cmd_p1_i(cmd_p1), .cmd_p2_i(cmd_p2),
    .instruction_o(ins_o[0]), .param_1_o(p1_o[0]), .param_2_o(p2_o[0]),
    .op_done_i(op_done), .data_i(data_in), .rd_data_o(rdd_o[0]), .rd_valid_o(rdv_o[0]),
    .busy_o(busy_o[0]), .timeout_o(tmo_o[0]), .fifo_count_o(cnt_o[0])
  );

  aether_engine_sequencer #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(TO_B)) dut_b (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(ready_o[1]),
    .cmd_instr_i(cmd_instr), .cmd_p1_i(cmd_p1), .cmd_p2_i(cmd_p2),
    .instruction_o(ins_o[1]), .param_1_o(p1_o[1]), .param_2_o(p2_o[1]),
    .op_done_i(op_done), .data_i(data_in), .rd_data_o(rdd_o[1]), .rd_valid_o(rdv_o[1]),
    .busy_o(busy_o[1]), .timeout_o(tmo_o[1]), .fifo_count_o(cnt_o[1])
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_mode [2];
  logic [23:0] m_q    [2][D];
  int          m_cnt  [2];
  logic [23:0] m_cur  [2];
  int          m_wc   [2];
  logic [15:0] m_rdd  [2];
  bit          m_rdv  [2];
  bit          m_to   [2];

  function automatic int to_lim(input int k);
    return (k == 0) ? TO_A : TO_B;
  endfunction

  function automatic bit is_long(input logic [23:0] c);
    logic [3:0] op, p;
    op = c[23:20];
    p  = c[19:16];
    return (op == OP_CNV) || (op == OP_DNS) ||
           ((op == OP_LDW) && (p == 4'h2 || p == 4'h3 || p == 4'h4));
  endfunction

  function automatic bit flush_now(input int k);
    logic [23:0] c;
    c = m_cur[k];
    return (m_mode[k] == M_ISSUE) && (c[23:20] == OP_RST) &&
           (c[19:16] != RST_ACC) && (c[19:16] != RST_BUF);
  endfunction

  function automatic bit model_ready(input int k);
    return !rst && (m_cnt[k] < D) && !flush_now(k);
  endfunction

  function automatic bit quiet();
    return m_mode[0] == M_IDLE && m_mode[1] == M_IDLE && m_cnt[0] == 0 && m_cnt[1] == 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_cnt[k] = 0; m_cur[k] = '0; m_wc[k] = 0;
      m_rdd[k] = '0; m_rdv[k] = 0; m_to[k] = 0;
    end
  endtask

  task automatic m_pop(input int k, output logic [23:0] c);
    c = m_q[k][0];
    for (int i = 0; i < D - 1; i++) m_q[k][i] = m_q[k][i+1];
    m_cnt[k]--;
  endtask

  // Advance each model across one rising edge using the inputs now driven.
  task automatic model_step();
    logic [23:0] w;
    w = {cmd_instr, cmd_p1, cmd_p2};
    for (int k = 0; k < 2; k++) begin
      bit fl, pu;
      logic [23:0] c;
      fl = flush_now(k);
      pu = cmd_valid && model_ready(k);
      m_rdv[k] = 0;
      case (m_mode[k])
        M_IDLE: begin
          if (m_cnt[k] > 0) begin
            m_pop(k, c); m_cur[k] = c; m_mode[k] = M_ISSUE;
          end else m_cur[k] = '0;
        end
        M_ISSUE: begin
          c = m_cur[k];
          if (c[23:20] == OP_RDR) begin m_rdd[k] = data_in; m_rdv[k] = 1; end
          if (fl) begin
            m_cnt[k] = 0; m_to[k] = 0; m_mode[k] = M_IDLE; m_cur[k] = '0;
          end else if (is_long(m_cur[k])) begin
            m_mode[k] = M_WAIT; m_wc[k] = 0; m_cur[k] = '0;
          end else if (m_cnt[k] > 0) begin
            m_pop(k, c); m_cur[k] = c;
          end else begin
            m_mode[k] = M_IDLE; m_cur[k] = '0;
          end
        end
        default: begin
          m_cur[k] = '0;
          m_wc[k]++;
          if (op_done) m_mode[k] = M_IDLE;
          else if (m_wc[k] == to_lim(k)) begin m_mode[k] = M_IDLE; m_to[k] = 1; end
        end
      endcase
      if (pu) begin
        m_q[k][m_cnt[k]] = w;
        m_cnt[k]++;
        $display("push dut%0d t=%0t instr=%h p1=%h p2=%h occ=%0d", k, $time,
                 cmd_instr, cmd_p1, cmd_p2, m_cnt[k]);
      end
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      logic [23:0] c;
      c = m_cur[k];
      check_val($sformatf("instr[%0d]", k), 32'(ins_o[k]), 32'(c[23:20]));
      check_val($sformatf("p1[%0d]", k),    32'(p1_o[k]),  32'(c[19:16]));
      check_val($sformatf("p2[%0d]", k),    32'(p2_o[k]),  32'(c[15:0]));
      check_val($sformatf("rd_data[%0d]", k),  32'(rdd_o[k]),  32'(m_rdd[k]));
      check_val($sformatf("rd_valid[%0d]", k), 32'(rdv_o[k]),  32'(m_rdv[k]));
      check_val($sformatf("busy[%0d]", k),     32'(busy_o[k]),
                32'(m_mode[k] != M_IDLE || m_cnt[k] > 0));
      check_val($sformatf("timeout[%0d]", k),  32'(tmo_o[k]),   32'(m_to[k]));
      check_val($sformatf("count[%0d]", k),    32'(cnt_o[k]),   32'(m_cnt[k]));
    end
  endtask

  task automatic check_ready();
    for (int k = 0; k < 2; k++)
      check_val($sformatf("ready[%0d]", k), 32'(ready_o[k]), 32'(model_ready(k)));
  endtask

  task automatic drive(input bit v, input logic [3:0] i, input logic [3:0] p,
                       input logic [15:0] d2, input bit dn);
    cmd_valid = v; cmd_instr = i; cmd_p1 = p; cmd_p2 = d2; op_done = dn;
    data_in = 16'($urandom);
  endtask

  // Called shortly after a rising edge with inputs already driven.
  task automatic cycle();
    #1;
    check_ready();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic settle(input string tag);
    for (int t = 0; t < 60 && !quiet(); t++) begin
      drive(0, OP_NOP, 4'h0, 16'h0, (m_mode[0] == M_WAIT || m_mode[1] == M_WAIT));
      cycle();
    end
    check_val(tag, 32'(busy_o[0] | busy_o[1]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  idx, rdv_seen, dt, wt;
    bit  saw_wrr, fl, acc, dn;

    rst = 1'b0;
    drive(0, OP_NOP, 4'h0, 16'h0, 0);
    model_reset();
    #1 rst = 1'b1;
    #2;
    check_outputs();
    check_ready();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) check_val($sformatf("ready_after_rst[%0d]", k), 32'(ready_o[k]), 32'd1);

    // ---- burst: two WRRs and an RDR issued on consecutive cycles
    rdv_seen = 0;
    drive(1, OP_WRR, REG_MEMUP, 16'h1234, 0); cycle(); rdv_seen += int'(rdv_o[1]);
    drive(1, OP_WRR, REG_MSTRT, 16'h0010, 0); cycle(); rdv_seen += int'(rdv_o[1]);
    drive(1, OP_RDR, REG_MEMUP, 16'h0000, 0); cycle(); rdv_seen += int'(rdv_o[1]);
    for (int t = 0; t < 6; t++) begin
      drive(0, OP_NOP, 4'h0, 16'h0, 0); cycle(); rdv_seen += int'(rdv_o[1]);
    end
    check_val("burst_rdv_pulses", 32'(rdv_seen), 32'd1);

    // ---- timeout on dut_a, then a full RST clears the sticky flag
    drive(1, OP_DNS, 4'h3, 16'h0042, 0); cycle();
    for (int t = 0; t < 20 && !m_to[0]; t++) begin
      drive(0, OP_NOP, 4'h0, 16'h0, 0); cycle();
    end
    check_val("timeout_set_a", 32'(tmo_o[0]), 32'd1);
    check_val("timeout_b_clear", 32'(tmo_o[1]), 32'd0);
    drive(1, OP_RST, RST_FULL, 16'h0, 0); cycle();
    settle("settle_timeout");
    check_val("timeout_cleared_a", 32'(tmo_o[0]), 32'd0);

    // ---- long op on dut_b: op_done in the 10th WAIT cycle releases the WRR
    drive(1, OP_CNV, 4'h2, 16'h0400, 0); cycle();
    drive(1, OP_WRR, REG_MEMUP, 16'h00AA, 0); cycle();
    dt = -100; wt = -200;
    for (int t = 0; t < 40 && !quiet(); t++) begin
      dn = (m_mode[1] == M_WAIT && m_wc[1] == 9);
      drive(0, OP_NOP, 4'h0, 16'h0, dn); cycle();
      if (dn) dt = t;
      if (ins_o[1] == OP_WRR && wt < 0) wt = t;
    end
    // Sampled after each edge: IDLE follows the op_done cycle, WRR the next.
    check_val("longop_wrr_gap", 32'(wt - dt), 32'd1);
    check_val("longop_no_timeout_b", 32'(tmo_o[1]), 32'd0);
    settle("settle_longop");

    // ---- full FIFO while waiting; held push accepted once a slot frees
    drive(1, OP_CNV, 4'h1, 16'h0001, 0); cycle();
    idx = 0;
    for (int t = 0; t < 40 && idx < 5; t++) begin
      drive(1, OP_WRR, 4'(idx), 16'(16'h0100 + idx), (m_mode[1] == M_WAIT && m_wc[1] == 5));
      acc = model_ready(1);
      cycle();
      if (acc) begin
        idx++;
        if (idx == 4) begin
          check_val("full_count_a", 32'(cnt_o[0]), 32'd4);
          check_val("full_count_b", 32'(cnt_o[1]), 32'd4);
          check_val("full_ready_b", 32'(ready_o[1]), 32'd0);
        end
      end
    end
    check_val("full_all_accepted", 32'(idx), 32'd5);
    settle("settle_full");

    // ---- flush: RST_FULL queued ahead of three WRRs
    drive(1, OP_CNV, 4'h0, 16'h0002, 0); cycle();
    drive(1, OP_RST, RST_FULL, 16'h0, 0); cycle();
    for (int j = 0; j < 3; j++) begin
      drive(1, OP_WRR, REG_MSTRT, 16'(16'h0200 + j), 0); cycle();
    end
    saw_wrr = 0;
    for (int t = 0; t < 40 && !quiet(); t++) begin
      drive(0, OP_NOP, 4'h0, 16'h0, (m_mode[1] == M_WAIT && m_wc[1] >= 3));
      fl = flush_now(1);
      cycle();
      if (ins_o[0] == OP_WRR || ins_o[1] == OP_WRR) saw_wrr = 1;
      if (fl) check_val("flush_count", 32'(cnt_o[1]), 32'd0);
    end
    check_val("flush_no_wrr", 32'(saw_wrr), 32'd0);
    settle("settle_flush");

    // ---- asynchronous reset mid-WAIT with a queued command
    drive(1, OP_CNV, 4'h3, 16'h0003, 0); cycle();
    drive(1, OP_WRR, REG_MEMUP, 16'h0777, 0); cycle();
    for (int t = 0; t < 3; t++) begin
      drive(0, OP_NOP, 4'h0, 16'h0, 0); cycle();
    end
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check_ready();
    drive(0, OP_NOP, 4'h0, 16'h0, 1);
    @(posedge clk); #1;
    check_outputs();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) check_val($sformatf("ready_after_rst2[%0d]", k), 32'(ready_o[k]), 32'd1);
    for (int t = 0; t < 3; t++) begin
      drive(0, OP_NOP, 4'h0, 16'h0, 1); cycle();
    end

    // ---- randomized traffic
    for (int t = 0; t < 400; t++) begin
      drive(bit'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5)),
            16'($urandom), ($urandom_range(0, 5) == 0));
      cycle();
    end
    settle("settle_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
